ip4_rtl_spa_pipe: RTL and testbench

- Parametrised SIMD integer execution pipeline for the IP4 stream processor array.
- Generalises the per-FU lane datapath in three ways: lane count and word width are parametrised, the output is registered with a configurable depth, and the pipeline supports stall, flush, result forwarding and per-lane overflow exceptions.
- Sits between the register-file read stage and the vector write-back stage. One instance is placed per functional unit.

---
 rtl/ip4_rtl_pkg.sv | 39 +++
 rtl/ip4_rtl_spa_lane.sv | 115 +++++++++++
 rtl/ip4_rtl_spa_pipe.sv | 128 ++++++++++++
 tb/tb_ip4_rtl_spa_pipe.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ip4_rtl_pkg.sv
// Shared opcode encoding and forwarding-select bit positions for the IP4 SPA pipeline.
package ip4_rtl_pkg;

    typedef enum logic [4:0] {
        OP_NOP  = 5'd0,
        OP_BP0  = 5'd1,
        OP_BP1  = 5'd2,
        OP_BP2  = 5'd3,
        OP_BP3  = 5'd4,
        OP_AND  = 5'd5,
        OP_OR   = 5'd6,
        OP_XOR  = 5'd7,
        OP_NOR  = 5'd8,
        OP_ADD  = 5'd9,
        OP_UADD = 5'd10,
        OP_SUB  = 5'd11,
        OP_USUB = 5'd12,
        OP_SRL  = 5'd13,
        OP_SRA  = 5'd14,
        OP_SLL  = 5'd15,
        OP_ROR  = 5'd16,
        OP_LID  = 5'd17,
        OP_SHF  = 5'd18,
        OP_MAX  = 5'd19,
        OP_MIN  = 5'd20,
        OP_UMAX = 5'd21,
        OP_UMIN = 5'd22,
        OP_CLO  = 5'd23,
        OP_CLZ  = 5'd24
    } spa_op_e;

    localparam int unsigned FWD_OP0 = 0;
    localparam int unsigned FWD_OP1 = 1;

    function automatic logic f_op_illegal(input logic [4:0] op);
        return op > OP_CLZ;
    endfunction

endpackage

// File: rtl/ip4_rtl_spa_lane.sv
// Combinational single-lane ALU of the SPA pipeline.
// Define IP4_SPA_SAT_EN to make signed add/sub saturate instead of wrapping.
module ip4_rtl_spa_lane
    import ip4_rtl_pkg::*;
#(
    parameter int unsigned WORD_BITS   = 32,
    parameter int unsigned NUM_SP      = 8,
    parameter int unsigned SUBVEC_BITS = 2,
    parameter int unsigned LANE_IDX    = 0
) (
    input  logic [4:0]             i_op,
    input  logic                   i_en,
    input  logic [WORD_BITS-1:0]   i_a,
    input  logic [WORD_BITS-1:0]   i_b,
    input  logic [WORD_BITS-1:0]   i_c,
    input  logic [WORD_BITS-1:0]   i_d,
    input  logic [WORD_BITS-1:0]   i_shf,
    input  logic [SUBVEC_BITS-1:0] i_subvec,
    output logic [WORD_BITS-1:0]   o_res0,
    output logic [WORD_BITS-1:0]   o_res1,
    output logic                   o_ovf
);

    localparam int unsigned SH_W = $clog2(WORD_BITS);
    localparam logic [WORD_BITS-1:0] SMAX = {1'b0, {(WORD_BITS-1){1'b1}}};
    localparam logic [WORD_BITS-1:0] SMIN = {1'b1, {(WORD_BITS-1){1'b0}}};
`ifdef IP4_SPA_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic [SH_W-1:0]      w_sh;
    logic [SH_W:0]        w_rsh;
    logic [WORD_BITS:0]   w_usum;
    logic [WORD_BITS:0]   w_udif;
    logic [WORD_BITS-1:0] w_lid_off;
    logic                 w_add_ovf;
    logic                 w_sub_ovf;

    function automatic logic [WORD_BITS-1:0] f_lead_zeros(input logic [WORD_BITS-1:0] x);
        logic [WORD_BITS-1:0] cnt;
        logic                 done;
        cnt  = WORD_BITS'(WORD_BITS);
        done = 1'b0;
        for (int unsigned k = 0; k < WORD_BITS; k++) begin
            if (!done && x[WORD_BITS-1-k]) begin
                cnt  = WORD_BITS'(k);
                done = 1'b1;
            end
        end
        return cnt;
    endfunction

    assign w_sh      = i_b[SH_W-1:0];
    assign w_rsh     = (SH_W+1)'(WORD_BITS) - {1'b0, w_sh};
    assign w_usum    = {1'b0, i_a} + {1'b0, i_b};
    assign w_udif    = {1'b0, i_a} - {1'b0, i_b};
    assign w_add_ovf = (i_a[WORD_BITS-1] == i_b[WORD_BITS-1]) && (w_usum[WORD_BITS-1] != i_a[WORD_BITS-1]);
    assign w_sub_ovf = (i_a[WORD_BITS-1] != i_b[WORD_BITS-1]) && (w_udif[WORD_BITS-1] != i_a[WORD_BITS-1]);
    assign w_lid_off = WORD_BITS'(LANE_IDX) + WORD_BITS'(i_subvec) * WORD_BITS'(NUM_SP);

    always_comb begin
        o_res0 = '0;
        o_res1 = '0;
        o_ovf  = 1'b0;
        case (spa_op_e'(i_op))
            OP_NOP:  o_res0 = i_a;
            OP_BP0:  o_res0 = i_a;
            OP_BP1:  o_res0 = i_b;
            OP_BP2:  o_res0 = i_c;
            OP_BP3:  o_res0 = i_d;
            OP_AND:  o_res0 = i_a & i_b;
            OP_OR:   o_res0 = i_a | i_b;
            OP_XOR:  o_res0 = i_a ^ i_b;
            OP_NOR:  o_res0 = ~(i_a | i_b);
            // On overflow the true result's sign is the sign of a for both add and sub
            OP_ADD: begin
                o_ovf  = w_add_ovf;
                o_res0 = (SAT_EN && w_add_ovf) ? (i_a[WORD_BITS-1] ? SMIN : SMAX) : w_usum[WORD_BITS-1:0];
            end
            OP_SUB: begin
                o_ovf  = w_sub_ovf;
                o_res0 = (SAT_EN && w_sub_ovf) ? (i_a[WORD_BITS-1] ? SMIN : SMAX) : w_udif[WORD_BITS-1:0];
            end
            OP_UADD: begin
                o_res0 = w_usum[WORD_BITS-1:0];
                o_res1 = WORD_BITS'(w_usum[WORD_BITS]);
            end
            OP_USUB: begin
                o_res0 = w_udif[WORD_BITS-1:0];
                o_res1 = WORD_BITS'(w_udif[WORD_BITS]);
            end
            OP_SRL:  o_res0 = i_a >> w_sh;
            OP_SRA:  o_res0 = $signed(i_a) >>> w_sh;
            OP_SLL:  o_res0 = i_a << w_sh;
            OP_ROR:  o_res0 = (i_a >> w_sh) | (i_a << w_rsh);
            OP_LID:  o_res0 = i_a + w_lid_off;
            OP_SHF:  o_res0 = i_shf;
            OP_MAX:  o_res0 = ($signed(i_a) > $signed(i_b)) ? i_a : i_b;
            OP_MIN:  o_res0 = ($signed(i_a) < $signed(i_b)) ? i_a : i_b;
            OP_UMAX: o_res0 = (i_a > i_b) ? i_a : i_b;
            OP_UMIN: o_res0 = (i_a < i_b) ? i_a : i_b;
            OP_CLO:  o_res0 = f_lead_zeros(~i_a);
            OP_CLZ:  o_res0 = f_lead_zeros(i_a);
            default: ;
        endcase
        if (!i_en) begin
            o_res0 = '0;
            o_res1 = '0;
            o_ovf  = 1'b0;
        end
    end

endmodule

// File: rtl/ip4_rtl_spa_pipe.sv
// Parametrised SIMD integer execution pipeline with stall, flush, forwarding and overflow count.
// Optional IP4_SPA_SAT_EN (in ip4_rtl_spa_lane) selects saturating signed add/sub.
module ip4_rtl_spa_pipe
    import ip4_rtl_pkg::*;
#(
    parameter int unsigned NUM_SP      = 8,
    parameter int unsigned WORD_BITS   = 32,
    parameter int unsigned EXE_STAGES  = 2,
    parameter int unsigned SUBVEC_BITS = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_vld,
    input  logic                          stall,
    input  logic                          flush,
    input  logic [4:0]                    opcode,
    input  logic [SUBVEC_BITS-1:0]        subvec,
    input  logic [NUM_SP-1:0]             emsk,
    input  logic [1:0]                    fwd_sel,
    input  logic [NUM_SP*WORD_BITS-1:0]   op0,
    input  logic [NUM_SP*WORD_BITS-1:0]   op1,
    input  logic [NUM_SP*WORD_BITS-1:0]   op2,
    input  logic [NUM_SP*WORD_BITS-1:0]   op3,
    output logic                          out_vld,
    output logic [NUM_SP*WORD_BITS-1:0]   res0,
    output logic [NUM_SP*WORD_BITS-1:0]   res1,
    output logic [NUM_SP-1:0]             out_emsk,
    output logic [NUM_SP-1:0]             ovf,
    output logic                          ill,
    output logic [15:0]                   exp_cnt
);

    localparam int unsigned VW   = NUM_SP * WORD_BITS;
    localparam int unsigned SP_W = $clog2(NUM_SP);
    localparam int unsigned LAST = EXE_STAGES - 1;

    logic [VW-1:0]     w_a;
    logic [VW-1:0]     w_b;
    logic [VW-1:0]     w_res0;
    logic [VW-1:0]     w_res1;
    logic [NUM_SP-1:0] w_ovf;
    logic              w_ill;

    logic [VW-1:0]     r_fwd;
    logic [15:0]       r_exp_cnt;
    logic              r_vld  [EXE_STAGES];
    logic [VW-1:0]     r_res0 [EXE_STAGES];
    logic [VW-1:0]     r_res1 [EXE_STAGES];
    logic [NUM_SP-1:0] r_emsk [EXE_STAGES];
    logic [NUM_SP-1:0] r_ovf  [EXE_STAGES];
    logic              r_ill  [EXE_STAGES];

    assign w_a   = fwd_sel[FWD_OP0] ? r_fwd : op0;
    assign w_b   = fwd_sel[FWD_OP1] ? r_fwd : op1;
    assign w_ill = f_op_illegal(opcode);

    for (genvar i = 0; i < NUM_SP; i++) begin : g_lane
        logic [SP_W-1:0] w_sidx;
        assign w_sidx = w_b[i*WORD_BITS +: SP_W];

        ip4_rtl_spa_lane #(
            .WORD_BITS  (WORD_BITS),
            .NUM_SP     (NUM_SP),
            .SUBVEC_BITS(SUBVEC_BITS),
            .LANE_IDX   (i)
        ) u_lane (
            .i_op    (opcode),
            .i_en    (emsk[i]),
            .i_a     (w_a[i*WORD_BITS +: WORD_BITS]),
            .i_b     (w_b[i*WORD_BITS +: WORD_BITS]),
            .i_c     (op2[i*WORD_BITS +: WORD_BITS]),
            .i_d     (op3[i*WORD_BITS +: WORD_BITS]),
            .i_shf   (w_a[w_sidx*WORD_BITS +: WORD_BITS]),
            .i_subvec(subvec),
            .o_res0  (w_res0[i*WORD_BITS +: WORD_BITS]),
            .o_res1  (w_res1[i*WORD_BITS +: WORD_BITS]),
            .o_ovf   (w_ovf[i])
        );
    end

    // Flush only clears valid bits; stale data behind a cleared valid is never observed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < EXE_STAGES; k++) begin
                r_vld[k]  <= 1'b0;
                r_res0[k] <= '0;
                r_res1[k] <= '0;
                r_emsk[k] <= '0;
                r_ovf[k]  <= '0;
                r_ill[k]  <= 1'b0;
            end
            r_fwd     <= '0;
            r_exp_cnt <= '0;
        end else begin
            if (flush) begin
                for (int unsigned k = 0; k < EXE_STAGES; k++) r_vld[k] <= 1'b0;
            end else if (!stall) begin
                r_vld[0]  <= in_vld;
                r_res0[0] <= w_res0;
                r_res1[0] <= w_res1;
                r_emsk[0] <= emsk;
                r_ovf[0]  <= w_ovf;
                r_ill[0]  <= w_ill;
                for (int unsigned k = 1; k < EXE_STAGES; k++) begin
                    r_vld[k]  <= r_vld[k-1];
                    r_res0[k] <= r_res0[k-1];
                    r_res1[k] <= r_res1[k-1];
                    r_emsk[k] <= r_emsk[k-1];
                    r_ovf[k]  <= r_ovf[k-1];
                    r_ill[k]  <= r_ill[k-1];
                end
            end
            if (out_vld && !stall) begin
                r_fwd <= res0;
                if ((|ovf) && (r_exp_cnt != 16'hFFFF)) r_exp_cnt <= r_exp_cnt + 16'd1;
            end
        end
    end

    assign out_vld  = r_vld[LAST];
    assign res0     = r_res0[LAST];
    assign res1     = r_res1[LAST];
    assign out_emsk = r_emsk[LAST];
    assign ovf      = r_ovf[LAST];
    assign ill      = r_ill[LAST] & r_vld[LAST];
    assign exp_cnt  = r_exp_cnt;

endmodule

// File: tb/tb_ip4_rtl_spa_pipe.sv
// Scoreboard testbench for ip4_rtl_spa_pipe with directed, hand-computed vectors.
module tb_ip4_rtl_spa_pipe;

    localparam int NSP = 8;
    localparam int W   = 32;
    localparam int VW  = NSP * W;
    localparam int LAT = 2;

    localparam int C_BP2 = 3,  C_XOR = 7,  C_ADD = 9,  C_UADD = 10, C_SUB = 11, C_USUB = 12;
    localparam int C_SRA = 14, C_ROR = 16, C_LID = 17, C_SHF = 18,  C_MAX = 19, C_UMAX = 21;
    localparam int C_CLO = 23, C_CLZ = 24, C_ILL = 27;

    logic          clk = 1'b0;
    logic          rst_n, in_vld, stall, flush;
    logic [4:0]    opcode;
    logic [1:0]    subvec;
    logic [7:0]    emsk;
    logic [1:0]    fwd_sel;
    logic [VW-1:0] op0, op1, op2, op3;
    logic          out_vld;
    logic [VW-1:0] res0, res1;
    logic [7:0]    out_emsk, ovf;
    logic          ill;
    logic [15:0]   exp_cnt;

    ip4_rtl_spa_pipe #(
        .NUM_SP     (NSP),
        .WORD_BITS  (W),
        .EXE_STAGES (LAT),
        .SUBVEC_BITS(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .stall(stall), .flush(flush),
        .opcode(opcode), .subvec(subvec), .emsk(emsk), .fwd_sel(fwd_sel),
        .op0(op0), .op1(op1), .op2(op2), .op3(op3),
        .out_vld(out_vld), .res0(res0), .res1(res1), .out_emsk(out_emsk),
        .ovf(ovf), .ill(ill), .exp_cnt(exp_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string         name;
        int            cyc;
        logic [VW-1:0] r0;
        logic [VW-1:0] r1;
        logic [7:0]    msk;
        logic [7:0]    ovf;
        logic          ill;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endtask

    function automatic logic [VW-1:0] rep(input logic [W-1:0] w);
        logic [VW-1:0] v;
        for (int i = 0; i < NSP; i++) v[i*W +: W] = w;
        return v;
    endfunction

    function automatic logic [VW-1:0] mask_vec(input logic [VW-1:0] v, input logic [7:0] m);
        logic [VW-1:0] r;
        for (int i = 0; i < NSP; i++) r[i*W +: W] = m[i] ? v[i*W +: W] : '0;
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick;
    endtask

    task automatic drive(input int op, input logic [7:0] m, input logic [1:0] fs,
                         input logic [VW-1:0] a, input logic [VW-1:0] b,
                         input logic [VW-1:0] c, input logic [1:0] sv);
        opcode  = 5'(op);
        emsk    = m;
        fwd_sel = fs;
        op0     = a;
        op1     = b;
        op2     = c;
        subvec  = sv;
        in_vld  = 1'b1;
    endtask

    task automatic issue(input string name, input int op, input logic [7:0] m, input logic [1:0] fs,
                         input logic [VW-1:0] a, input logic [VW-1:0] b, input logic [VW-1:0] c,
                         input logic [1:0] sv, input logic [VW-1:0] e0, input logic [VW-1:0] e1,
                         input logic [7:0] eovf, input logic eill, input int extra);
        exp_t e;
        drive(op, m, fs, a, b, c, sv);
        e.name = name;
        e.cyc  = cyc + LAT + extra;
        e.r0   = e0;
        e.r1   = e1;
        e.msk  = m;
        e.ovf  = eovf;
        e.ill  = eill;
        sb.push_back(e);
        tick;
        in_vld  = 1'b0;
        fwd_sel = 2'b00;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_vld) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_out: out_vld=1 at cycle %0d, required no output", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_cycle"}, VW'(cyc), VW'(mon_e.cyc));
                chk({mon_e.name, "_res0"},  res0, mon_e.r0);
                chk({mon_e.name, "_res1"},  res1, mon_e.r1);
                chk({mon_e.name, "_emsk"},  VW'(out_emsk), VW'(mon_e.msk));
                chk({mon_e.name, "_ovf"},   VW'(ovf), VW'(mon_e.ovf));
                chk({mon_e.name, "_ill"},   VW'(ill), VW'(mon_e.ill));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1);
    end

    logic [VW-1:0] va, vb, ve;
    logic [W-1:0]  e_add_ovf, e_sub_ovf;
    int            seen;

    initial begin
`ifdef IP4_SPA_SAT_EN
        e_add_ovf = 32'h7FFF_FFFF;
        e_sub_ovf = 32'h8000_0000;
`else
        e_add_ovf = 32'h8000_0000;
        e_sub_ovf = 32'h7FFF_FFFF;
`endif
        rst_n = 1'b0; in_vld = 1'b0; stall = 1'b0; flush = 1'b0;
        opcode = '0; subvec = '0; emsk = '0; fwd_sel = '0;
        op0 = '0; op1 = '0; op2 = '0; op3 = '0;
        idle(3);
        chk("rst_out_vld",  VW'(out_vld), '0);
        chk("rst_res0",     res0, '0);
        chk("rst_res1",     res1, '0);
        chk("rst_out_emsk", VW'(out_emsk), '0);
        chk("rst_ovf",      VW'(ovf), '0);
        chk("rst_ill",      VW'(ill), '0);
        chk("rst_exp_cnt",  VW'(exp_cnt), '0);
        rst_n = 1'b1;
        tick;

        issue("add_lat", C_ADD, 8'hFF, 2'b00, rep(5), rep(7), '0, 2'd0, rep(12), '0, 8'h00, 1'b0, 0);
        idle(3);

        issue("add_ovf", C_ADD, 8'h0F, 2'b00, rep(32'h7FFF_FFFF), rep(1), '0, 2'd0,
              mask_vec(rep(e_add_ovf), 8'h0F), '0, 8'h0F, 1'b0, 0);
        idle(4);
        chk("exp_cnt_1", VW'(exp_cnt), VW'(1));

        issue("sub_ovf", C_SUB, 8'hFF, 2'b00, rep(32'h8000_0000), rep(1), '0, 2'd0,
              rep(e_sub_ovf), '0, 8'hFF, 1'b0, 0);
        idle(4);
        chk("exp_cnt_2", VW'(exp_cnt), VW'(2));

        issue("uadd_stall", C_UADD, 8'hFF, 2'b00, rep(32'hFFFF_FFFF), rep(2), '0, 2'd0,
              rep(1), rep(1), 8'h00, 1'b0, 3);
        stall = 1'b1;
        idle(3);
        stall = 1'b0;
        idle(4);

        issue("usub", C_USUB, 8'hFF, 2'b00, rep(3), rep(5), '0, 2'd0,
              rep(32'hFFFF_FFFE), rep(1), 8'h00, 1'b0, 0);
        idle(3);

        drive(C_UADD, 8'hFF, 2'b00, rep(1), rep(1), '0, 2'd0);
        tick;
        drive(C_ADD, 8'hFF, 2'b00, rep(2), rep(2), '0, 2'd0);
        flush = 1'b1;
        stall = 1'b1;
        tick;
        flush = 1'b0; stall = 1'b0; in_vld = 1'b0;
        seen = 0;
        repeat (4) begin
            tick;
            if (out_vld) seen++;
        end
        chk("flush_quiet", VW'(seen), '0);

        issue("fwd_sub", C_SUB, 8'hFF, 2'b00, rep(10), rep(3), '0, 2'd0, rep(7), '0, 8'h00, 1'b0, 0);
        idle(3);
        issue("fwd_op0", C_ADD, 8'hFF, 2'b01, rep(100), rep(1), '0, 2'd0, rep(8), '0, 8'h00, 1'b0, 0);
        idle(3);
        issue("fwd_op1", C_ADD, 8'hFF, 2'b10, rep(2), rep(55), '0, 2'd0, rep(10), '0, 8'h00, 1'b0, 0);
        idle(3);

        for (int i = 0; i < NSP; i++) begin
            va[i*W +: W] = 32'(i * 16);
            vb[i*W +: W] = 32'(7 - i);
            ve[i*W +: W] = 32'((7 - i) * 16);
        end
        issue("shf", C_SHF, 8'hFF, 2'b00, va, vb, '0, 2'd0, ve, '0, 8'h00, 1'b0, 0);
        for (int i = 0; i < NSP; i++) ve[i*W +: W] = 32'(16 + i);
        issue("lid", C_LID, 8'hFF, 2'b00, '0, '0, '0, 2'd2, ve, '0, 8'h00, 1'b0, 0);
        issue("clz", C_CLZ, 8'hFF, 2'b00, rep(32'h0001_0000), '0, '0, 2'd0, rep(15), '0, 8'h00, 1'b0, 0);
        issue("clo", C_CLO, 8'hFF, 2'b00, rep(32'hFFFF_FFFF), '0, '0, 2'd0, rep(32), '0, 8'h00, 1'b0, 0);
        issue("clz0", C_CLZ, 8'hFF, 2'b00, '0, '0, '0, 2'd0, rep(32), '0, 8'h00, 1'b0, 0);
        issue("xor_msk", C_XOR, 8'h55, 2'b00, rep(32'hF0F0_F0F0), rep(32'hFF00_FF00), '0, 2'd0,
              mask_vec(rep(32'h0FF0_0FF0), 8'h55), '0, 8'h00, 1'b0, 0);
        issue("sra", C_SRA, 8'hFF, 2'b00, rep(32'h8000_0000), rep(4), '0, 2'd0,
              rep(32'hF800_0000), '0, 8'h00, 1'b0, 0);
        issue("ror", C_ROR, 8'hFF, 2'b00, rep(32'h1234_5678), rep(8), '0, 2'd0,
              rep(32'h7812_3456), '0, 8'h00, 1'b0, 0);
        issue("max", C_MAX, 8'hFF, 2'b00, rep(32'hFFFF_FFFF), rep(1), '0, 2'd0, rep(1), '0, 8'h00, 1'b0, 0);
        issue("umax", C_UMAX, 8'hFF, 2'b00, rep(32'hFFFF_FFFF), rep(1), '0, 2'd0,
              rep(32'hFFFF_FFFF), '0, 8'h00, 1'b0, 0);
        issue("bp2", C_BP2, 8'hFF, 2'b00, rep(1), rep(2), rep(32'hCAFE_F00D), 2'd0,
              rep(32'hCAFE_F00D), '0, 8'h00, 1'b0, 0);
        issue("illegal", C_ILL, 8'hFF, 2'b00, rep(32'h1234), rep(5), '0, 2'd0, '0, '0, 8'h00, 1'b1, 0);
        idle(4);

        chk("exp_cnt_pre_rst", VW'(exp_cnt), VW'(2));
        drive(C_ADD, 8'hFF, 2'b00, rep(1), rep(1), '0, 2'd0);
        tick;
        in_vld = 1'b0;
        tick;
        chk("inflight_vld", VW'(out_vld), VW'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_vld",  VW'(out_vld), '0);
        chk("async_rst_res0", res0, '0);
        chk("async_rst_emsk", VW'(out_emsk), '0);
        chk("async_rst_cnt",  VW'(exp_cnt), '0);
        tick;
        rst_n = 1'b1;
        idle(2);

        chk("sb_drained", VW'(sb.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
